sort_stream_bitonic_iter: RTL and testbench

- Streaming counterpart to the packed combinational 16x8b sorters in the Synthetic sort family.
- Accepts N elements one per beat on a valid/ready input and sorts them in place with one shared bank of N/2 compare-exchange units, one bitonic pass per cycle.
- Returns the sorted elements one per beat on a valid/ready output.
- Used wherever sort data arrives and leaves serially rather than as one wide vector.

---
 rtl/sort_stream_bitonic_iter.sv | 147 ++++++++++++++
 tb/tb_sort_stream_bitonic_iter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_bitonic_iter.sv
// sort_stream_bitonic_iter
//   Collects N elements one per beat, sorts them in place with a single bank of
//   N/2 compare-exchange units (one bitonic pass per clock), then streams the
//   sorted elements back out one per beat.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   input element handshake, in_data is the element
//   out_valid/out_ready output element handshake, out_data is the element
//   out_last            marks the Nth output element of a block
//   busy                high while sorting or draining
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. The producer holds data stable while valid && !ready; ready never
// depends combinationally on valid.
module sort_stream_bitonic_iter #(
    parameter int N       = 16,
    parameter int W       = 8,
    parameter int DESCEND = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int LOGN = $clog2(N);
    localparam int PW   = $clog2(LOGN + 1);

    typedef logic [LOGN-1:0] idx_t;
    typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} state_t;

    localparam idx_t          CNT_LAST = {LOGN{1'b1}};
    localparam logic [PW-1:0] KL_LAST  = PW'(LOGN);
    localparam logic [PW-1:0] KL_FIRST = PW'(1);

    state_t        state_q, state_d;
    idx_t          cnt_q, cnt_d;     // write index in LOAD, read step in DRAIN
    logic [PW-1:0] kl_q, kl_d;       // log2 of bitonic block size k
    logic [PW-1:0] jl_q, jl_d;       // log2 of compare distance j
    logic          init_q;           // holds in_ready low for the first cycle out of reset
    logic [W-1:0]  mem_q [N];
    logic [W-1:0]  mem_d [N];

    int            jv, kv, l;
    logic [W-1:0]  a, b;
    logic          swap;
    idx_t          rd_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kl_d    = kl_q;
        jl_d    = jl_q;
        mem_d   = mem_q;
        jv      = 0;
        kv      = 0;
        l       = 0;
        a       = '0;
        b       = '0;
        swap    = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    mem_d[cnt_q] = in_data;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_SORT;
                        kl_d    = KL_FIRST;
                        jl_d    = '0;
                    end
                end
            end
            S_SORT: begin
                jv = 1 << jl_q;
                kv = 1 << kl_q;
                // Pairs (i, i^j) are disjoint, so every exchange reads the old
                // array and all of them land on the same edge.
                for (int i = 0; i < N; i++) begin
                    l = i ^ jv;
                    if (l > i) begin
                        a = mem_q[idx_t'(i)];
                        b = mem_q[idx_t'(l)];
                        // Strict compares: equal values stay where they are.
                        if ((i & kv) == 0) swap = (a > b);
                        else               swap = (a < b);
                        if (swap) begin
                            mem_d[idx_t'(i)] = b;
                            mem_d[idx_t'(l)] = a;
                        end
                    end
                end
                // j halves down to 1; then k doubles and j restarts at k/2.
                if (jl_q == '0) begin
                    if (kl_q == KL_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        kl_d = kl_q + 1'b1;
                        jl_d = kl_q;
                    end
                end else begin
                    jl_d = jl_q - 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            kl_q    <= '0;
            jl_q    <= '0;
            init_q  <= 1'b0;
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kl_q    <= kl_d;
            jl_q    <= jl_d;
            init_q  <= 1'b1;
            mem_q   <= mem_d;
        end
    end

    // Descending output is the ascending array read back to front.
    assign rd_idx    = (DESCEND != 0) ? ~cnt_q : cnt_q;
    assign in_ready  = (state_q == S_LOAD) && init_q;
    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = out_valid ? mem_q[rd_idx] : '0;
    assign out_last  = out_valid && (cnt_q == CNT_LAST);
    assign busy      = (state_q != S_LOAD);

endmodule

// File: tb/tb_sort_stream_bitonic_iter.sv
// Bench for sort_stream_bitonic_iter: an ascending and a descending instance
// share all inputs and run in lockstep; sel picks which one is observed.
module tb_sort_stream_bitonic_iter;

    localparam int N = 16;
    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         out_ready = 1'b0;

    logic         a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [W-1:0] a_out_data;
    logic         d_in_ready, d_out_valid, d_out_last, d_busy;
    logic [W-1:0] d_out_data;

    sort_stream_bitonic_iter #(.N(N), .W(W), .DESCEND(0)) dut_asc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .busy(a_busy)
    );

    sort_stream_bitonic_iter #(.N(N), .W(W), .DESCEND(1)) dut_desc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
        .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
        .out_last(d_out_last), .busy(d_busy)
    );

    logic         sel = 1'b0;
    logic         i_ready, o_valid, o_last, o_busy;
    logic [W-1:0] o_data;
    assign i_ready = sel ? d_in_ready  : a_in_ready;
    assign o_valid = sel ? d_out_valid : a_out_valid;
    assign o_data  = sel ? d_out_data  : a_out_data;
    assign o_last  = sel ? d_out_last  : a_out_last;
    assign o_busy  = sel ? d_busy      : a_busy;

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] vec [N];
    logic         hold = 1'b0;
    logic         rnd  = 1'b0;
    int           drain_cycles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference ordering by plain bubble sort of the stimulus vector.
    task automatic push_sorted();
        logic [W-1:0] t [N];
        logic [W-1:0] tmp;
        t = vec;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (t[j] > t[j+1]) begin
                    tmp = t[j]; t[j] = t[j+1]; t[j+1] = tmp;
                end
        for (int i = 0; i < N; i++) exp_q.push_back(t[i]);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a settled point (#1 after an edge); returns #1 after the Nth transfer edge.
    task automatic load_block();
        for (int i = 0; i < N; i++) begin
            int tmo;
            in_valid = 1'b1;
            in_data  = vec[i];
            tmo = 0;
            while (!i_ready && tmo < 100) begin
                @(posedge clk); #1;
                tmo++;
            end
            check("in_ready_load", i_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = hold;
        in_data  = hold ? 8'hEE : 8'h00;
    endtask

    task automatic wait_sort();
        int n;
        check("in_ready_drop", i_ready, 0);
        check("busy_sort", o_busy, 1);
        n = 0;
        while (!o_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            check("in_ready_sort", i_ready, 0);
        end
        check("sort_latency", n, 10);
    endtask

    task automatic drain();
        int           got, cyc;
        logic         stalled;
        logic [W-1:0] prev;
        logic [W-1:0] e;
        got = 0; cyc = 0; stalled = 1'b0; prev = '0;
        while (got < N && cyc < 300) begin
            check("out_valid_drain", o_valid, 1);
            check("in_ready_drain", i_ready, 0);
            if (stalled) check("stall_stable", o_data, prev);
            if (o_valid && out_ready) begin
                e = exp_q.pop_front();
                check("out_data", o_data, e);
                check("out_last", o_last, (got == N - 1));
                got++;
                stalled = 1'b0;
            end else begin
                stalled = o_valid;
                prev    = o_data;
            end
            @(posedge clk); #1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        drain_cycles = cyc;
        check("drain_count", got, N);
        check("out_valid_end", o_valid, 0);
        check("in_ready_end", i_ready, 1);
        check("busy_end", o_busy, 0);
        check("exp_q_empty", exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] t2 [N];
        logic [W-1:0] sh [N];
        t2 = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h5A, 8'h5A, 8'h5A, 8'h5A,
               8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        sh = '{8'd5, 8'd12, 8'd1, 8'd16, 8'd9, 8'd3, 8'd14, 8'd7,
               8'd2, 8'd11, 8'd15, 8'd6, 8'd10, 8'd4, 8'd13, 8'd8};

        // reset state
        #2;
        check("reset_outputs", {i_ready, o_valid, o_data, o_last, o_busy}, 0);
        #10 rst_n = 1'b1;
        #1;
        check("in_ready_pre_edge", i_ready, 0);
        @(posedge clk); #1;
        check("in_ready_after_reset", i_ready, 1);
        out_ready = 1'b1;

        // 1: descending input, continuous flow
        for (int i = 0; i < N; i++) vec[i] = 8'(15 - i);
        for (int i = 0; i < N; i++) exp_q.push_back(8'(i));
        load_block();
        wait_sort();
        drain();
        check("drain_cycles_continuous", drain_cycles, N);

        // 2: unsigned extremes and duplicates
        vec = t2;
        exp_q.push_back(8'h00);
        for (int i = 0; i < 12; i++) exp_q.push_back(8'h5A);
        exp_q.push_back(8'h7F);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'hFF);
        load_block();
        wait_sort();
        drain();

        // 3: random values, random downstream backpressure
        for (int i = 0; i < N; i++) vec[i] = 8'($urandom_range(0, 255));
        push_sorted();
        rnd = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        load_block();
        wait_sort();
        drain();
        rnd = 1'b0;
        out_ready = 1'b1;

        // 4: in_valid held high through SORT/DRAIN, three blocks back to back
        hold = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < N; i++) vec[i] = 8'($urandom_range(0, 15) * (b + 1));
            push_sorted();
            load_block();
            wait_sort();
            drain();
        end
        hold = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // 5: reset in the middle of SORT, then a clean block
        for (int i = 0; i < N; i++) vec[i] = 8'hC0 + 8'(i);
        load_block();
        repeat (4) @(posedge clk);
        #1;
        check("busy_before_reset", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_sort", {i_ready, o_valid, o_data, o_last, o_busy}, 0);
        @(posedge clk); #1;
        check("reset_held", {i_ready, o_valid, o_data, o_last, o_busy}, 0);
        rst_n = 1'b1;
        #1;
        check("in_ready_release", i_ready, 0);
        @(posedge clk); #1;
        check("in_ready_one_edge", i_ready, 1);
        vec = sh;
        for (int i = 1; i <= N; i++) exp_q.push_back(8'(i));
        load_block();
        wait_sort();
        drain();

        // 6: observe the DESCEND=1 instance
        sel = 1'b1;
        for (int i = 0; i < N; i++) vec[i] = 8'(i);
        for (int i = 0; i < N; i++) exp_q.push_back(8'(15 - i));
        load_block();
        wait_sort();
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench time limit");
    end

endmodule
